// File: rtl/controle_rega.sv
// controle_rega: irrigation sequencing controller (sensor sync, level decode, valve FSM).
// Optional input debounce filter on h/m/l/seco is built in when DEBOUNCE_EN is defined.
module controle_rega #(
    parameter int MIN_ON  = 16,
    parameter int FILL_TO = 1024,
    parameter int CNT_W   = 16
`ifdef DEBOUNCE_EN
    ,
    parameter int DB_LEN  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h,
    input  logic       m,
    input  logic       l,
    input  logic       seco,
    input  logic       clr,
    output logic       va,
    output logic       vs,
    output logic       bs,
    output logic       alarme,
    output logic [2:0] disp_code
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENCHER   = 3'd1,
        ASPERSAO = 3'd2,
        GOTEJO   = 3'd3,
        ERRO     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        VAZIO, BAIXO, MEDIO, CHEIO, INVALIDO
    } level_t;

    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TO - 1);

    // Two-flop synchronizer, packed as {h, m, l, seco, clr}.
    logic [4:0] sync_p0, sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {h, m, l, seco, clr};
            sync_p1 <= sync_p0;
        end
    end

    logic [3:0] sens;   // {h, m, l, seco} as seen by the decision logic
    logic       clr_s;

    assign clr_s = sync_p1[0];

`ifdef DEBOUNCE_EN
    localparam int DBC_W = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;

    logic [DBC_W-1:0] db_cnt [4];
    logic [3:0]       filt;

    // A sensor bit is accepted only after it has differed from the filtered value for DB_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i+1] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBC_W'(DB_LEN - 1)) begin
                    filt[i]   <= sync_p1[i+1];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sens = filt;
`else
    assign sens = sync_p1[4:1];
`endif

    level_t level;
    logic   seco_s;

    assign seco_s = sens[0];

    always_comb begin
        case (sens[3:1])
            3'b000:  level = VAZIO;
            3'b001:  level = BAIXO;
            3'b011:  level = MEDIO;
            3'b111:  level = CHEIO;
            default: level = INVALIDO;
        endcase
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        // ERRO ignores the vazio rule: only an acknowledged, valid level releases it.
        if (state == ERRO) begin
            if (clr_s && level != INVALIDO) state_nxt = OCIOSO;
        end else if (level == INVALIDO) begin
            state_nxt = ERRO;
        end else begin
            case (state)
                OCIOSO: begin
                    if (level == VAZIO)                                 state_nxt = ENCHER;
                    else if (seco_s && (level == MEDIO || level == CHEIO)) state_nxt = ASPERSAO;
                    else if (seco_s && level == BAIXO)                  state_nxt = GOTEJO;
                end
                ENCHER: begin
                    if (level == CHEIO)          state_nxt = OCIOSO;
                    else if (cnt == FILL_LAST)   state_nxt = ERRO;
                end
                ASPERSAO: begin
                    if (level == VAZIO)                    state_nxt = ENCHER;
                    else if (level == BAIXO)               state_nxt = GOTEJO;
                    else if (!seco_s && cnt >= MIN_ON_C)   state_nxt = OCIOSO;
                end
                GOTEJO: begin
                    if (level == VAZIO)                    state_nxt = ENCHER;
                    else if (!seco_s && cnt >= MIN_ON_C)   state_nxt = OCIOSO;
                end
                default: state_nxt = OCIOSO;
            endcase
        end

        if (state_nxt == state) begin
            case (state)
                ENCHER:          cnt_nxt = cnt + 1'b1;
                ASPERSAO, GOTEJO: cnt_nxt = (cnt < MIN_ON_C) ? cnt + 1'b1 : cnt;
                default:         cnt_nxt = '0;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OCIOSO;
            cnt       <= '0;
            va        <= 1'b0;
            vs        <= 1'b0;
            bs        <= 1'b0;
            alarme    <= 1'b0;
            disp_code <= 3'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            va        <= (state_nxt == ENCHER);
            vs        <= (state_nxt == ASPERSAO);
            bs        <= (state_nxt == GOTEJO);
            alarme    <= (state_nxt == ERRO);
            disp_code <= state_nxt;
        end
    end

endmodule

// File: tb/tb_controle_rega.sv
// Testbench for controle_rega: directed test-plan scenarios plus randomized sensor traffic,
// all checked each cycle against a behavioural model of the irrigation rules.
module tb_controle_rega;

    localparam int MIN_ON  = 4;
    localparam int FILL_TO = 20;

    localparam int S_OCIOSO = 0, S_ENCHER = 1, S_ASP = 2, S_GOT = 3, S_ERRO = 4;
    localparam int L_VAZIO = 0, L_BAIXO = 1, L_MEDIO = 2, L_CHEIO = 3, L_INV = 4;

    logic       clk = 1'b0;
    logic       rst, h, m, l, seco, clr;
    logic       va, vs, bs, alarme;
    logic [2:0] disp_code;

    always #5 clk = ~clk;

    controle_rega #(.MIN_ON(MIN_ON), .FILL_TO(FILL_TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .h(h), .m(m), .l(l), .seco(seco), .clr(clr),
        .va(va), .vs(vs), .bs(bs), .alarme(alarme), .disp_code(disp_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state, cycle counter and the pin vectors still in flight
    // through the two-cycle input latency, as {h,m,l,seco,clr}.
    int         m_state;
    int         m_cnt;
    logic [4:0] m_pipe[$];

    function automatic int level_of(input logic [2:0] hml);
        case (hml)
            3'b000:  return L_VAZIO;
            3'b001:  return L_BAIXO;
            3'b011:  return L_MEDIO;
            3'b111:  return L_CHEIO;
            default: return L_INV;
        endcase
    endfunction

    task automatic model_reset();
        m_state = S_OCIOSO;
        m_cnt   = 0;
        m_pipe  = {5'b0, 5'b0};
    endtask

    task automatic model_step(input logic [4:0] pins);
        logic [4:0] d;
        int lv, nxt;
        bit sc, ck;
        d   = m_pipe.pop_front();
        lv  = level_of(d[4:2]);
        sc  = d[1];
        ck  = d[0];
        nxt = m_state;
        if (m_state == S_ERRO) begin
            if (ck && lv != L_INV) nxt = S_OCIOSO;
        end else if (lv == L_INV) begin
            nxt = S_ERRO;
        end else if (m_state == S_OCIOSO) begin
            if (lv == L_VAZIO) nxt = S_ENCHER;
            else if (sc && lv >= L_MEDIO) nxt = S_ASP;
            else if (sc && lv == L_BAIXO) nxt = S_GOT;
        end else if (m_state == S_ENCHER) begin
            if (lv == L_CHEIO) nxt = S_OCIOSO;
            else if (m_cnt == FILL_TO - 1) nxt = S_ERRO;
        end else begin
            if (lv == L_VAZIO) nxt = S_ENCHER;
            else if (m_state == S_ASP && lv == L_BAIXO) nxt = S_GOT;
            else if (!sc && m_cnt >= MIN_ON) nxt = S_OCIOSO;
        end
        if (nxt != m_state) m_cnt = 0;
        else if (m_state == S_ENCHER) m_cnt = m_cnt + 1;
        else if (m_state == S_ASP || m_state == S_GOT) m_cnt = (m_cnt + 1 > MIN_ON) ? MIN_ON : m_cnt + 1;
        m_state = nxt;
        m_pipe.push_back(pins);
    endtask

    task automatic compare_outputs();
        check("va", va, m_state == S_ENCHER);
        check("vs", vs, m_state == S_ASP);
        check("bs", bs, m_state == S_GOT);
        check("alarme", alarme, m_state == S_ERRO);
        check("disp_code", disp_code, m_state);
        check("one_valve", (int'(va) + int'(vs) + int'(bs)) <= 1, 1);
    endtask

    // Drive pins at the falling edge, advance one clock, then compare at the next falling edge.
    task automatic step(input logic [2:0] hml, input logic s, input logic c);
        {h, m, l} = hml;
        seco = s;
        clr  = c;
        @(posedge clk);
        if (rst) model_reset();
        else model_step({hml, s, c});
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        int cnt_a;
        int r;
        logic [2:0] lvl_r;
        logic s_r;
        logic c_r;

        rst = 1'b1; h = 1'b0; m = 1'b0; l = 1'b0; seco = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with empty tank, then filling starts and stops at cheio.
        repeat (3) step(3'b000, 1'b0, 1'b0);
        check("t1_reset_va", va, 0);
        check("t1_reset_disp", disp_code, 0);
        rst = 1'b0;
        repeat (3) step(3'b000, 1'b0, 1'b0);
        check("t1_fill_va", va, 1);
        check("t1_fill_disp", disp_code, 1);
        repeat (7) step(3'b000, 1'b0, 1'b0);
        repeat (3) step(3'b111, 1'b0, 1'b0);
        check("t1_full_va", va, 0);
        check("t1_full_disp", disp_code, 0);

        // Sprinkler minimum on-time, then sustained demand.
        repeat (3) step(3'b011, 1'b0, 1'b0);
        step(3'b011, 1'b1, 1'b0);
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            step(3'b011, 1'b0, 1'b0);
            cnt_a += int'(vs);
        end
        check("t2_min_on", cnt_a >= MIN_ON, 1);
        check("t2_vs_off", vs, 0);
        check("t2_disp_idle", disp_code, 0);
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            step(3'b011, 1'b1, 1'b0);
            if (i >= 3) cnt_a += int'(vs);
        end
        check("t2_vs_hold", cnt_a, 27);

        // Level drop to baixo switches to drip; rising back does not return to sprinkler.
        repeat (3) step(3'b001, 1'b1, 1'b0);
        check("t3_bs_on", bs, 1);
        check("t3_vs_off", vs, 0);
        check("t3_disp", disp_code, 3);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b011, 1'b1, 1'b0);
            cnt_a += int'(bs);
        end
        check("t3_bs_stays", cnt_a, 10);

        // Empty tank: fill runs exactly FILL_TO cycles, then fault; clr re-arms.
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            step(3'b000, 1'b0, 1'b0);
            cnt_a += int'(va);
        end
        check("t4_fill_len", cnt_a, FILL_TO);
        check("t4_alarme", alarme, 1);
        check("t4_va_off", va, 0);
        check("t4_disp_err", disp_code, 4);
        step(3'b000, 1'b0, 1'b1);
        repeat (2) step(3'b000, 1'b0, 1'b0);
        check("t4_clr_idle", disp_code, 0);
        step(3'b000, 1'b0, 1'b0);
        check("t4_refill", disp_code, 1);

        // Invalid level from drip goes to fault; clr only honoured with a valid level.
        repeat (5) step(3'b111, 1'b0, 1'b0);
        repeat (5) step(3'b001, 1'b1, 1'b0);
        check("t5_drip", bs, 1);
        repeat (5) step(3'b101, 1'b1, 1'b0);
        check("t5_bs_off", bs, 0);
        check("t5_alarme", alarme, 1);
        step(3'b101, 1'b1, 1'b1);
        repeat (4) step(3'b101, 1'b1, 1'b0);
        check("t5_clr_ignored", disp_code, 4);
        repeat (3) step(3'b111, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b1);
        repeat (3) step(3'b111, 1'b0, 1'b0);
        check("t5_clr_exit", disp_code, 0);
        check("t5_alarme_off", alarme, 0);

        // Asynchronous reset between clock edges while sprinkling.
        repeat (6) step(3'b011, 1'b1, 1'b0);
        check("t6_vs_on", vs, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_vs", vs, 0);
        check("t6_async_disp", disp_code, 0);
        model_reset();
        @(negedge clk);
        compare_outputs();
        repeat (2) step(3'b011, 1'b1, 1'b0);
        rst = 1'b0;

        // Randomized sensor traffic with slowly varying levels.
        lvl_r = 3'b011;
        s_r   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    lvl_r = 3'b000;
                    2, 3:    lvl_r = 3'b001;
                    4, 5:    lvl_r = 3'b011;
                    6, 7:    lvl_r = 3'b111;
                    default: lvl_r = 3'($urandom_range(0, 7));
                endcase
            end
            if ($urandom_range(0, 9) == 0) s_r = ~s_r;
            c_r = ($urandom_range(0, 15) == 0);
            step(lvl_r, s_r, c_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_rega.md
Name: controle_rega

Overview:
- Sequencing controller for the automated irrigation datapath.
- Samples the tank level sensors h/m/l and the soil-dry sensor, then drives three actuators: the inlet valve, the sprinkler valve vs and the drip valve bs.
- Emits a 3-bit state code that feeds the existing seven-segment decoders.
- Sits between the raw sensor pins and both the actuator outputs and the display segment logic.

Parameters:
- MIN_ON, 16: minimum cycles a sprinkler or drip cycle stays on once started.
- FILL_TO, 1024: fill timeout, in cycles, before declaring a fault.
- CNT_W, 16: cycle-counter width; must satisfy 2^CNT_W > max(MIN_ON, FILL_TO).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- h  in  1  tank-high sensor (1 = water at level).
- m  in  1  tank-medium sensor.
- l  in  1  tank-low sensor.
- seco  in  1  soil-dry sensor (1 = irrigation requested).
- clr  in  1  fault acknowledge, one-cycle pulse.
- va  out  1  inlet (fill) valve.
- vs  out  1  sprinkler valve.
- bs  out  1  drip valve.
- alarme  out  1  fault indicator.
- disp_code  out  3  state code: 0 OCIOSO, 1 ENCHER, 2 ASPERSAO, 3 GOTEJO, 4 ERRO.

Behaviour:
- Input conditioning:
  - h, m, l, seco and clr each pass through a 2-flop synchronizer; all decisions use the synchronized values.
  - Pin-to-decision latency is 2 cycles; one further cycle to the registered outputs.
- Level decode of {h,m,l}:
  - 000 = vazio, 001 = baixo, 011 = medio, 111 = cheio.
  - Any other pattern = invalido.
- All outputs are registered, and one-hot with the state:
  - va=1 only in ENCHER; vs=1 only in ASPERSAO; bs=1 only in GOTEJO; alarme=1 only in ERRO.
  - At no time may two valves be 1 simultaneously.
- Reset (async, any time including mid-cycle):
  - state=OCIOSO; cnt=0; va=vs=bs=alarme=0; disp_code=0.
  - Synchronizer flops cleared to 0.
- Transition priority, evaluated every cycle: invalido > vazio > state-specific rules.
- OCIOSO:
  - invalido -> ERRO; vazio -> ENCHER.
  - seco and level medio or cheio -> ASPERSAO.
  - seco and level baixo -> GOTEJO.
  - Otherwise stay. cnt cleared on every state entry.
- ENCHER:
  - cnt increments each cycle.
  - Level cheio -> OCIOSO.
  - cnt reaches FILL_TO-1 without cheio -> ERRO.
  - seco is ignored while filling.
- ASPERSAO:
  - cnt increments, saturating at MIN_ON.
  - Level drops to baixo -> GOTEJO, with cnt cleared.
  - vazio -> ENCHER.
  - Not seco and cnt >= MIN_ON -> OCIOSO.
  - Not seco and cnt < MIN_ON -> stay.
- GOTEJO:
  - Same rules as ASPERSAO, except a level rise to medio or cheio does NOT switch to ASPERSAO mid-cycle.
  - vazio -> ENCHER; not seco and cnt >= MIN_ON -> OCIOSO.
- ERRO:
  - All valves off, alarme=1.
  - Exits to OCIOSO only when the synchronized clr=1 in a cycle where the level is valid.
  - clr with invalid level is ignored; clr in any other state is ignored.
- cnt arithmetic:
  - Unsigned CNT_W bits.
  - Saturates in ASPERSAO/GOTEJO and never wraps.
  - In ENCHER, bounded by the FILL_TO transition.

Optional Feature:
- Macro: DEBOUNCE_EN.
- When defined:
  - Adds parameter DB_LEN (default 4).
  - Each of h, m, l and seco updates its filtered value only after holding a new synchronized value for DB_LEN consecutive cycles.
  - Pin-to-decision latency becomes 2+DB_LEN cycles.
  - clr is not filtered.
  - Reset clears the filter counters, and the filtered values reset to 0.
- When undefined: synchronizer only, with the latency stated above.

Test Plan (MIN_ON=4, FILL_TO=20, no DEBOUNCE_EN):
1. Reset with h,m,l=000 -> outputs all 0, disp_code=0. Release reset -> ENCHER (va=1, disp_code=1) within 3 cycles. Drive 111 at cycle 10 -> va=0, disp_code=0 within 3 cycles.
2. Level 011, seco pulsed high for 1 cycle -> vs=1 for at least 4 cycles, then vs=0 and disp_code=0. Hold seco=1 for 30 cycles -> vs stays 1 throughout.
3. In ASPERSAO with seco=1, level changes 011->001 -> vs=0 and bs=1 the same cycle, disp_code=3, never both high. Then 001->011 -> bs stays 1.
4. Level 000 held for 25 cycles -> va=1, then ERRO after 20 cycles in ENCHER: alarme=1, va=0, disp_code=4. clr pulse while level is 000 -> OCIOSO, then ENCHER again.
5. Level 101 (invalid) from GOTEJO -> ERRO, bs=0, alarme=1. clr while still 101 -> stays ERRO. Set 111, then clr -> OCIOSO.
6. Assert rst asynchronously mid-ASPERSAO, between clock edges -> vs=0 and disp_code=0 immediately, before the next clk edge.
